// File: rtl/bram_arb2.sv
// bram_arb2: two-requester arbiter in front of one simple-dual-port BRAM.
// Requester 0 is the host loader, requester 1 the compute engine. At most one
// BRAM read or write is issued per cycle. Arbitration is round-robin with
// bounded burst ownership, and read data returns to the issuer one cycle later.
// Optional build macro BRAM_ARB_FIXED_PRIO_EN: requester 0 always wins when
// valid, and the burst counter is held at zero.
module bram_arb2 #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MAX_BURST     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_0,
  output logic                     req_ready_1,
  input  logic                     req_we_0,
  input  logic                     req_we_1,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_0,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0]    req_wdata_0,
  input  logic [DATA_WIDTH-1:0]    req_wdata_1,
  output logic                     rsp_valid_0,
  output logic                     rsp_valid_1,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_0,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_1,
  output logic                     bram_we,
  output logic [ADDRESS_WIDTH-1:0] bram_rd_addr,
  output logic [ADDRESS_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0]    bram_d_in,
  input  logic [DATA_WIDTH-1:0]    bram_d_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rsp_pend_0_q, rsp_pend_0_d;
  logic             rsp_pend_1_q, rsp_pend_1_d;

  logic gnt_vld;    // some requester is selected this cycle
  logic gnt_sel;    // selected requester index (0 when none)
  logic accept;     // selection is turned into a real BRAM operation
  logic sel_we;     // write flag of the selected requester
  logic own_sel;    // index of the current owner in OWNi states
  logic own_valid;  // owner is requesting
  logic oth_valid;  // non-owner is requesting

  // Grant decision from current state and request valids.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    gnt_vld   = 1'b0;
    gnt_sel   = 1'b0;
    own_sel   = (state_q == OWN1);
    own_valid = own_sel ? req_valid_1 : req_valid_0;
    oth_valid = own_sel ? req_valid_0 : req_valid_1;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    if (req_valid_0) begin
      gnt_vld = 1'b1;
      gnt_sel = 1'b0;
    end else if (req_valid_1) begin
      gnt_vld = 1'b1;
      gnt_sel = 1'b1;
    end
`else
    case (state_q)
      OWN0, OWN1: begin
        // Owner keeps the port until its burst is used up and the other waits.
        if (own_valid && ((burst_cnt_q < MAX_CNT) || !oth_valid)) begin
          gnt_vld = 1'b1;
          gnt_sel = own_sel;
        end else if (oth_valid) begin
          gnt_vld = 1'b1;
          gnt_sel = ~own_sel;
        end
      end
      default: begin
        if (req_valid_0 && req_valid_1) begin
          gnt_vld = 1'b1;
          gnt_sel = ~last_q;
        end else if (req_valid_0 || req_valid_1) begin
          gnt_vld = 1'b1;
          gnt_sel = req_valid_1;
        end
      end
    endcase
`endif
  end

  assign accept = gnt_vld & ~rst;
  assign sel_we = gnt_sel ? req_we_1 : req_we_0;

  // Next owner, burst count and pending read responses.
  always_comb begin
    state_d      = IDLE;
    last_d       = last_q;
    burst_cnt_d  = '0;
    rsp_pend_0_d = accept & ~gnt_sel & ~sel_we;
    rsp_pend_1_d = accept & gnt_sel & ~sel_we;
    if (gnt_vld) begin
      state_d = gnt_sel ? OWN1 : OWN0;
      last_d  = gnt_sel;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      if (state_q == state_d) begin
        burst_cnt_d = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + CNT_W'(1) : burst_cnt_q;
      end else begin
        burst_cnt_d = CNT_W'(1);
      end
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      burst_cnt_q  <= '0;
      rsp_pend_0_q <= 1'b0;
      rsp_pend_1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      burst_cnt_q  <= burst_cnt_d;
      rsp_pend_0_q <= rsp_pend_0_d;
      rsp_pend_1_q <= rsp_pend_1_d;
    end
  end

  // Readies and the BRAM write strobe are suppressed while reset is asserted.
  assign req_ready_0  = accept & ~gnt_sel;
  assign req_ready_1  = accept & gnt_sel;
  assign bram_we      = accept & sel_we;
  // With no grant gnt_sel is 0, so the BRAM port shows requester 0's inputs.
  assign bram_rd_addr = gnt_sel ? req_addr_1 : req_addr_0;
  assign bram_wr_addr = gnt_sel ? req_addr_1 : req_addr_0;
  assign bram_d_in    = gnt_sel ? req_wdata_1 : req_wdata_0;

  // A read issued just before reset must not surface during reset.
  assign rsp_valid_0  = rsp_pend_0_q & ~rst;
  assign rsp_valid_1  = rsp_pend_1_q & ~rst;
  assign rsp_rdata_0  = bram_d_out;
  assign rsp_rdata_1  = bram_d_out;

endmodule

// File: tb/tb_bram_arb2.sv
// tb_bram_arb2: directed bench for bram_arb2. Two instances share the request
// stimulus: instance 0 with MAX_BURST=4, instance 1 with MAX_BURST=1. Each has
// its own BRAM model and its own reference model checked every cycle.
module tb_bram_arb2;

  localparam int MB_A = 4;
  localparam int MB_B = 1;
`ifdef BRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, we0, we1;
  logic [7:0] a0, a1, d0, d1;

  logic [1:0]      rdy0, rdy1, rv0, rv1, bwe;
  logic [1:0][7:0] rd0, rd1, rda, wra, din, dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_arb2 #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .MAX_BURST(MB_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid_0(v0), .req_valid_1(v1),
    .req_ready_0(rdy0[0]), .req_ready_1(rdy1[0]),
    .req_we_0(we0), .req_we_1(we1),
    .req_addr_0(a0), .req_addr_1(a1),
    .req_wdata_0(d0), .req_wdata_1(d1),
    .rsp_valid_0(rv0[0]), .rsp_valid_1(rv1[0]),
    .rsp_rdata_0(rd0[0]), .rsp_rdata_1(rd1[0]),
    .bram_we(bwe[0]), .bram_rd_addr(rda[0]), .bram_wr_addr(wra[0]),
    .bram_d_in(din[0]), .bram_d_out(dout[0])
  );

  bram_arb2 #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .MAX_BURST(MB_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid_0(v0), .req_valid_1(v1),
    .req_ready_0(rdy0[1]), .req_ready_1(rdy1[1]),
    .req_we_0(we0), .req_we_1(we1),
    .req_addr_0(a0), .req_addr_1(a1),
    .req_wdata_0(d0), .req_wdata_1(d1),
    .rsp_valid_0(rv0[1]), .rsp_valid_1(rv1[1]),
    .rsp_rdata_0(rd0[1]), .rsp_rdata_1(rd1[1]),
    .bram_we(bwe[1]), .bram_rd_addr(rda[1]), .bram_wr_addr(wra[1]),
    .bram_d_in(din[1]), .bram_d_out(dout[1])
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // BRAM models: registered read, preloaded on the first edge (under reset).
  logic [7:0] mem [2][256];
  logic mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 256; a++) mem[k][a] <= init_val(8'(a));
      mem_loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (bwe[k]) mem[k][wra[k]] <= din[k];
        dout[k] <= mem[k][rda[k]];
      end
    end
  end

  // Reference model state: who owned the port, for how many consecutive
  // grants, who was served last, pending responses and a shadow memory.
  int         owner [2];
  int         run   [2];
  logic       last  [2];
  logic       pend  [2][2];
  logic [7:0] pdata [2][2];
  logic [7:0] shadow[2][256];
  logic       sh_loaded = 1'b0;

  function automatic int model_grant(input int k);
`ifdef BRAM_ARB_FIXED_PRIO_EN
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`else
    int mb;
    mb = (k == 0) ? MB_A : MB_B;
    if (!v0 && !v1) return -1;
    if (v0 && !v1)  return 0;
    if (v1 && !v0)  return 1;
    if (owner[k] >= 0 && run[k] < mb) return owner[k];
    return last[k] ? 0 : 1;
`endif
  endfunction

  // Compare process: checks both instances against the model every cycle.
  always @(negedge clk) begin : cmp
    int         g;
    logic       wg;
    logic [7:0] ag, dg;
    if (!sh_loaded) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 256; a++) shadow[k][a] <= init_val(8'(a));
      sh_loaded <= 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      g  = rst ? -1 : model_grant(k);
      wg = (g == 1) ? we1 : we0;
      ag = (g == 1) ? a1 : a0;
      dg = (g == 1) ? d1 : d0;
      check($sformatf("m_ready0_i%0d", k), rdy0[k], g == 0);
      check($sformatf("m_ready1_i%0d", k), rdy1[k], g == 1);
      check($sformatf("m_bram_we_i%0d", k), bwe[k], (g >= 0) && wg);
      if (!rst) begin
        check($sformatf("m_rd_addr_i%0d", k), rda[k], ag);
        check($sformatf("m_wr_addr_i%0d", k), wra[k], ag);
        check($sformatf("m_d_in_i%0d", k), din[k], dg);
      end
      check($sformatf("m_rsp_valid0_i%0d", k), rv0[k], pend[k][0] && !rst);
      check($sformatf("m_rsp_valid1_i%0d", k), rv1[k], pend[k][1] && !rst);
      if (pend[k][0] && !rst) check($sformatf("m_rsp_rdata0_i%0d", k), rd0[k], pdata[k][0]);
      if (pend[k][1] && !rst) check($sformatf("m_rsp_rdata1_i%0d", k), rd1[k], pdata[k][1]);
      if (rst) begin
        owner[k]   <= -1;
        run[k]     <= 0;
        last[k]    <= 1'b1;
        pend[k][0] <= 1'b0;
        pend[k][1] <= 1'b0;
      end else begin
        pend[k][0] <= (g == 0) && !wg;
        pend[k][1] <= (g == 1) && !wg;
        if (g >= 0) begin
          pdata[k][g] <= shadow[k][ag];
          if (wg) shadow[k][ag] <= dg;
          run[k]   <= (g == owner[k]) ? run[k] + 1 : 1;
          owner[k] <= g;
          last[k]  <= (g == 1);
        end else begin
          owner[k] <= -1;
          run[k]   <= 0;
        end
      end
    end
  end

  // One cycle of stimulus; returns just after the following falling edge.
  task automatic drive(input logic iv0, input logic iwe0, input logic [7:0] ia0,
                       input logic [7:0] id0, input logic iv1, input logic iwe1,
                       input logic [7:0] ia1, input logic [7:0] id1);
    @(posedge clk);
    #1;
    v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
    v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  int exp_a[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int exp_b[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    // Reset with a pending write request that must be masked.
    rst = 1'b1;
    v0 = 1'b1; we0 = 1'b1; a0 = 8'h33; d0 = 8'h99;
    v1 = 1'b0; we1 = 1'b0; a1 = 8'h00; d1 = 8'h00;
    @(negedge clk);
    #1;
    check("rst_ready0", rdy0[0], 1'b0);
    check("rst_bram_we", bwe[0], 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; v0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    #1;
    check("reset_rsp_valid0", rv0[0], 1'b0);
    check("reset_ready0", rdy0[0], 1'b0);

    // Single read of the preloaded word.
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rd_ready0", rdy0[0], 1'b1);
    check("rd_ready1", rdy1[0], 1'b0);
    idle();
    check("rd_rsp_valid0", rv0[0], 1'b1);
    check("rd_rsp_rdata0", rd0[0], 8'hA5);
    check("rd_rsp_valid1", rv1[0], 1'b0);
    idle();
    check("rd_rsp_valid0_once", rv0[0], 1'b0);

    // Write then read of the same address by requester 1.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h07, 8'h3C);
    check("wr_bram_we", bwe[0], 1'b1);
    check("wr_addr", wra[0], 8'h07);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00);
    check("wr_then_rd_we", bwe[0], 1'b0);
    idle();
    check("wr_rd_rsp_valid1", rv1[0], 1'b1);
    check("wr_rd_rsp_rdata1", rd1[0], 8'h3C);
    idle();

    // Contention from IDLE with requester 1 served last.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00);
      check($sformatf("cont_a_grant_%0d", i), rdy1[0], FIXED ? 0 : exp_a[i]);
      check($sformatf("cont_b_grant_%0d", i), rdy1[1], FIXED ? 0 : exp_b[i]);
      check($sformatf("cont_a_one_ready_%0d", i), rdy0[0] ^ rdy1[0], 1'b1);
    end

    // Requester 1 drops out: requester 0 served every cycle, no stall.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h50, 8'h00);
      check($sformatf("gap_b_ready0_%0d", i), rdy0[1], 1'b1);
    end

    // Read accepted, then reset on the next cycle with writes pending.
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check("pre_rst_ready0", rdy0[0], 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      v0 = 1'b1; we0 = 1'b1; a0 = 8'h60; d0 = 8'hEE;
      v1 = 1'b1; we1 = 1'b1; a1 = 8'h61; d1 = 8'hDD;
      @(negedge clk);
      #1;
      check($sformatf("midrst_rsp_valid0_%0d", i), rv0[0], 1'b0);
      check($sformatf("midrst_ready0_%0d", i), rdy0[0], 1'b0);
      check($sformatf("midrst_ready1_%0d", i), rdy1[1], 1'b0);
      check($sformatf("midrst_we_a_%0d", i), bwe[0], 1'b0);
      check($sformatf("midrst_we_b_%0d", i), bwe[1], 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    v0 = 1'b1; we0 = 1'b0; a0 = 8'h60; d0 = 8'h00;
    v1 = 1'b1; we1 = 1'b0; a1 = 8'h61; d1 = 8'h00;
    @(negedge clk);
    #1;
    check("post_rst_tie_a", rdy0[0], 1'b1);
    check("post_rst_tie_b", rdy0[1], 1'b1);

    // Long solo run by requester 0 saturates the burst count, then a tie.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'h60, 8'h00, 1'b0, 1'b0, 8'h61, 8'h00);
      check($sformatf("solo_rsp_%0d", i), rd0[0], 8'h3A);
    end
    drive(1'b1, 1'b0, 8'h60, 8'h00, 1'b1, 1'b0, 8'h61, 8'h00);
    check("sat_switch_a", rdy1[0], FIXED ? 1'b0 : 1'b1);

    // Mixed reads and writes with gaps; the model checks every cycle.
    for (int i = 0; i < 24; i++) begin
      drive((i % 3) != 2, i[0], 8'(i % 8), 8'(i * 7),
            (i % 4) != 0, i[1], 8'((i + 3) % 8), 8'(i * 11 + 1));
    end
    idle();

`ifdef BRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00);
      check($sformatf("fixed_ready0_%0d", i), rdy0[0], 1'b1);
    end
    drive(1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00);
    check("fixed_ready1_on_drop", rdy1[0], 1'b1);
`endif

    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_arb2.md
Name: bram_arb2

Overview:
- Two-requester arbiter that shares one simple-dual-port BRAM (separate read/write address, 1-cycle registered read) between a host loader (requester 0) and a compute engine (requester 1).
- Issues at most one BRAM operation per cycle, either a read or a write.
- Uses round-robin arbitration with bounded burst ownership.
- Routes read data back to the requester that issued the read, with fixed 1-cycle latency.

Parameters:
- DATA_WIDTH, 8, BRAM word width.
- ADDRESS_WIDTH, 8, BRAM address width.
- MAX_BURST, 4, maximum consecutive accepted operations by one owner while the other requester waits; legal range 1..255.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid_0, req_valid_1  in  1 each  request valid.
- req_ready_0, req_ready_1  out  1 each  request accepted this cycle (combinational).
- req_we_0, req_we_1  in  1 each  1 = write, 0 = read.
- req_addr_0, req_addr_1  in  ADDRESS_WIDTH each  target address.
- req_wdata_0, req_wdata_1  in  DATA_WIDTH each  write data.
- rsp_valid_0, rsp_valid_1  out  1 each  read data valid (registered).
- rsp_rdata_0, rsp_rdata_1  out  DATA_WIDTH each  read data.
- bram_we  out  1  BRAM write enable.
- bram_rd_addr  out  ADDRESS_WIDTH  BRAM read address.
- bram_wr_addr  out  ADDRESS_WIDTH  BRAM write address.
- bram_d_in  out  DATA_WIDTH  BRAM write data.
- bram_d_out  in  DATA_WIDTH  BRAM read data, valid 1 cycle after address.

Behaviour:
- **State.** States are IDLE, OWN0, OWN1. Registers: last (last owner served), burst_cnt (ceil(log2(MAX_BURST+1)) bits), rsp_pend_0, rsp_pend_1.
- **Reset values.** State=IDLE, last=1 (requester 0 wins the first tie), burst_cnt=0, rsp_valid_0/1=0.
  - While rst=1: req_ready_0/1=0 and bram_we=0.
- **Grant decision** (combinational, per cycle). g = selected requester, or none.
  - IDLE:
    - one valid: g = that requester.
    - both valid: g = the requester that is not last.
    - none valid: none.
  - OWNi:
    - valid_i and (burst_cnt < MAX_BURST or valid_j=0): g=i.
    - else if valid_j: g=j.
    - else if valid_i: g=i.
    - else: none.
- **Acceptance.** req_ready_g=1, the other ready=0; an op is accepted when valid&ready.
- **Next state.**
  - g=i: state=OWNi, last=i.
  - burst_cnt = burst_cnt+1 if i was already owner, else 1.
  - burst_cnt saturates at MAX_BURST.
  - No grant: IDLE, burst_cnt=0, last unchanged.
- **BRAM drive.**
  - bram_rd_addr = bram_wr_addr = req_addr_g; bram_d_in = req_wdata_g.
  - When no grant: addresses and data hold the requester-0 inputs.
  - bram_we = accepted & req_we_g.
- **Read response.** An accepted read in cycle T sets rsp_valid_g=1 in cycle T+1 for exactly 1 cycle. rsp_rdata_g = bram_d_out, combinational passthrough to both requesters.
  - No backpressure on responses; requesters must sink them.
- **Write.** No response. Write then read of the same address in consecutive cycles returns the new data, because they are separate BRAM cycles.
- **Throughput.** 1 op/cycle. No bubble on owner switch.
- **Reset mid-operation.** A read accepted in the cycle before rst rises gets no rsp_valid. No write is issued during rst.
- **MAX_BURST=1.** With both requesters continuously valid, grants strictly alternate.
- **Protocol.** Requester inputs must remain stable while valid=1 and ready=0. The arbiter does not check this.

Optional Feature:
- **Macro: BRAM_ARB_FIXED_PRIO_EN.**
  - **Defined:** requester 0 always wins whenever req_valid_0=1. MAX_BURST and last are ignored; burst_cnt is held at 0; state still tracks the owner. Requester 1 can starve.
  - **Undefined:** round-robin/burst behaviour as specified above.

Test Plan:
- **Single read.** rst 2 cycles; BRAM preloaded addr 0x10=0xA5. req_valid_0=1, we=0, addr=0x10 in cycle T -> req_ready_0=1 in T; rsp_valid_0=1, rsp_rdata_0=0xA5 in T+1 only; rsp_valid_1=0 throughout.
- **Write then read.** Req1 writes 0x3C to 0x07 in T, reads 0x07 in T+1 -> bram_we=1 in T only; rsp_valid_1=1 with 0x3C in T+2.
- **Contention, MAX_BURST=4.** Both requesters continuously valid with reads from IDLE -> grant sequence is 0,0,0,0,1,1,1,1,0,… with exactly one ready per cycle.
- **MAX_BURST=1 with gaps.** Both valid -> alternate 0,1,0,1. Drop valid_1 -> requester 0 granted every cycle with no stall.
- **Reset mid-op.** Read accepted in T, rst=1 in T+1 -> rsp_valid_0=0 in T+1; readies=0 and bram_we=0 during rst. After release, a tie is granted to requester 0.
- **With BRAM_ARB_FIXED_PRIO_EN.** Both valid for 10 cycles -> requester 0 granted all 10 cycles, requester 1 none. Requester 1 is granted the cycle valid_0 drops.
